// File: rtl/gpr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_wr_arbiter
//
// Shares the single GPR write port (we / ws / wData) between NREQ writeback
// requesters. Each requester uses a valid/ready handshake; the grant is
// round-robin, and a requester may keep the port for several consecutive
// beats by holding req_lock high. All GPR-side outputs are registered, so a
// beat accepted in cycle N appears on gpr_* in cycle N+1.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   DW    write data width
//   AW    register address width
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester write pending
//   req_lock   per-requester "keep the port after this beat"
//   req_addr   destination registers, requester i in [i*AW +: AW]
//   req_data   write data, requester i in [i*DW +: DW]
//   req_ready  one-hot grant (combinational); beat accepted on valid & ready
//   hold       pipeline stall, suppresses all grants
//   gpr_we     registered write enable (0 for register 0)
//   gpr_ws     registered write select
//   gpr_wData  registered write data
//   stall_cnt  (GPR_WR_ARB_STATS_EN only) 16-bit saturating count per
//              requester of cycles spent valid but not ready
//   lock_owner one-hot owner while the port is locked, else 0
//
// Optional build macro: GPR_WR_ARB_STATS_EN adds stall_cnt and its counters.
// ---------------------------------------------------------------------------
module gpr_wr_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic                 gpr_we,
    output logic [AW-1:0]        gpr_ws,
    output logic [DW-1:0]        gpr_wData,
`ifdef GPR_WR_ARB_STATS_EN
    output logic [NREQ*16-1:0]   stall_cnt,
`endif
    output logic [NREQ-1:0]      lock_owner
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_owner_idx;
    logic [NREQ-1:0]    r_lock_owner;
    logic               r_gpr_we;
    logic [AW-1:0]      r_gpr_ws;
    logic [DW-1:0]      r_gpr_wdata;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic               w_found;
    logic [PW-1:0]      w_arb_idx;
    logic [PW-1:0]      w_grant_idx;
    logic               w_grant_ok;
    logic [NREQ-1:0]    w_grant_onehot;
    logic [AW-1:0]      w_acc_addr;
    logic [DW-1:0]      w_acc_data;
    logic               w_acc_lock;
    logic [PW-1:0]      w_next_ptr;

    // Round-robin scan starting at r_rr_ptr; the first valid requester wins.
    always_comb begin
        w_found   = 1'b0;
        w_arb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found   = 1'b1;
                w_arb_idx = PW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    // While locked only the owner is eligible, regardless of rr_ptr.
    // The grant depends only on inputs and internal state, never on gpr_*.
    always_comb begin
        w_grant_idx = (r_state == ST_LOCKED) ? r_owner_idx : w_arb_idx;
        if (rst || hold) begin
            w_grant_ok = 1'b0;
        end else if (r_state == ST_LOCKED) begin
            w_grant_ok = req_valid[r_owner_idx];
        end else begin
            w_grant_ok = w_found;
        end
        w_grant_onehot = NREQ'(1) << w_grant_idx;
        req_ready      = w_grant_ok ? w_grant_onehot : '0;
    end

    // The granted requester is valid by construction, so a grant is an
    // accepted beat.
    assign w_acc_addr = req_addr[int'(w_grant_idx) * AW +: AW];
    assign w_acc_data = req_data[int'(w_grant_idx) * DW +: DW];
    assign w_acc_lock = req_lock[w_grant_idx];
    assign w_next_ptr = (int'(w_grant_idx) == NREQ - 1) ? '0 : w_grant_idx + PW'(1);

    // ------------------------------------------------------------------
    // Arbitration FSM and registered GPR write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ARB;
            r_rr_ptr     <= '0;
            r_owner_idx  <= '0;
            r_lock_owner <= '0;
            r_gpr_we     <= 1'b0;
            r_gpr_ws     <= '0;
            r_gpr_wdata  <= '0;
        end else begin
            // Register 0 is hardwired: the beat is consumed but never written.
            r_gpr_we <= w_grant_ok && (w_acc_addr != '0);
            if (w_grant_ok) begin
                r_gpr_ws    <= w_acc_addr;
                r_gpr_wdata <= w_acc_data;
                r_rr_ptr    <= w_next_ptr;
                case (r_state)
                    ST_ARB: begin
                        if (w_acc_lock) begin
                            r_state      <= ST_LOCKED;
                            r_owner_idx  <= w_grant_idx;
                            r_lock_owner <= w_grant_onehot;
                        end
                    end
                    ST_LOCKED: begin
                        // Only a beat with lock low releases the port; the
                        // owner idling with valid low keeps it locked.
                        if (!w_acc_lock) begin
                            r_state      <= ST_ARB;
                            r_lock_owner <= '0;
                        end
                    end
                    default: begin
                        r_state      <= ST_ARB;
                        r_lock_owner <= '0;
                    end
                endcase
            end
        end
    end

    assign gpr_we     = r_gpr_we;
    assign gpr_ws     = r_gpr_ws;
    assign gpr_wData  = r_gpr_wdata;
    assign lock_owner = r_lock_owner;

`ifdef GPR_WR_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Per-requester stall counters (valid but not granted), saturating.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [15:0] r_stall_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stall_cnt <= '0;
                end else if (req_valid[gi] && !req_ready[gi] && (r_stall_cnt != 16'hFFFF)) begin
                    r_stall_cnt <= r_stall_cnt + 16'd1;
                end
            end
            assign stall_cnt[gi*16 +: 16] = r_stall_cnt;
        end
    endgenerate
`endif

endmodule
